// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand sequencer and the ALU it drives.
package alu_pkg;

  localparam int W_DEF   = 4;
  localparam int OPW_DEF = 3;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_CAP  = 3'd4,
    S_SHOW = 3'd5
  } state_e;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_LT  = 3'd6;
  localparam logic [2:0] OP_EQ  = 3'd7;

endpackage

// File: rtl/btn_debounce.sv
// Raw button to one-cycle press pulse: 2-flop synchroniser, stability counter,
// registered rising-edge detector on the debounced level.
module btn_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          db_q, db_prev_q, pulse_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      pulse_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      // Any return to the debounced level restarts the stability window.
      if (sync2_q == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
        db_q  <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      db_prev_q <= db_q;
      pulse_q   <= db_q & ~db_prev_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Button-driven entry of A, B and op code into the ALU, then capture and hold
// of its result for the display.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int OPW       = OPW_DEF,
  parameter int DB_CYCLES = 1000000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   sw,
  input  logic [OPW-1:0] op_sw,
  input  logic           btn_next,
  input  logic           btn_clr,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_ctrl,
  input  logic [W-1:0]   alu_res,
  input  logic           alu_car,
  input  logic           alu_of,
  output logic [W-1:0]   res_q,
  output logic           car_q,
  output logic           of_q,
  output logic           done,
  output logic [2:0]     state_o
);

  logic next_p, clr_p;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_next),
    .pulse   (next_p)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_clr),
    .pulse   (clr_p)
  );

  state_e         state_q;
  logic [W-1:0]   a_q, b_q, res_r_q;
  logic [OPW-1:0] ctrl_q;
  logic           car_r_q, of_r_q, done_q;

  // Presses in S_EXEC/S_CAP fall through untouched, so they are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      res_r_q <= '0;
      car_r_q <= 1'b0;
      of_r_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (clr_p) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      res_r_q <= '0;
      car_r_q <= 1'b0;
      of_r_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_A: if (next_p) begin
          a_q     <= sw;
          state_q <= S_B;
        end
        S_B: if (next_p) begin
          b_q     <= sw;
          state_q <= S_OP;
        end
        S_OP: if (next_p) begin
          ctrl_q  <= op_sw;
          state_q <= S_EXEC;
        end
        S_EXEC: state_q <= S_CAP;
        S_CAP: begin
          res_r_q <= alu_res;
          car_r_q <= alu_car;
          of_r_q  <= alu_of;
          done_q  <= 1'b1;
          state_q <= S_SHOW;
        end
        S_SHOW: if (next_p) begin
          done_q  <= 1'b0;
          state_q <= S_A;
        end
        default: state_q <= S_A;
      endcase
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_ctrl = ctrl_q;
  assign res_q    = res_r_q;
  assign car_q    = car_r_q;
  assign of_q     = of_r_q;
  assign done     = done_q;
  assign state_o  = state_q;

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Upstream stage of the 4-bit combinational ALU on the board.
- Turns slide switches and two push-buttons into registered operands A, B and a 3-bit op code, then drives them into the ALU.
- Samples the ALU result, carry and overflow one cycle later and holds them stable for the downstream 7-segment display logic.
- Contains button synchronisers, debouncers, edge detectors and a 6-state entry FSM.

Parameters:
- W, 4, operand and result width.
- OPW, 3, ALU op-code width.
- DB_CYCLES, 1000000, cycles a synchronised button level must stay stable before the debounced level changes; benches use 4.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sw  input  W  operand switches.
- op_sw  input  OPW  op-code switches.
- btn_next  input  1  advance button, raw and asynchronous.
- btn_clr  input  1  clear button, raw and asynchronous.
- alu_a  output  W  registered operand A to ALU.
- alu_b  output  W  registered operand B to ALU.
- alu_ctrl  output  OPW  registered op code to ALU.
- alu_res  input  W  ALU result, combinational from alu_a/alu_b/alu_ctrl.
- alu_car  input  1  ALU carry.
- alu_of  input  1  ALU overflow.
- res_q  output  W  captured result.
- car_q  output  1  captured carry.
- of_q  output  1  captured overflow.
- done  output  1  high while captured values are valid.
- state_o  output  3  current FSM state encoding, for LEDs.

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous active-low. While rst_n=0:
  - all outputs and internal registers are 0; state = S_A.
  - synchroniser flops are 0; debounce counters are 0; debounced levels are 0.
- Button path, identical for each button:
  - 2-flop synchroniser.
  - Debounce counter: clears whenever the synchronised level equals the debounced level; otherwise increments. When it reaches DB_CYCLES-1, the debounced level takes the synchronised level and the counter clears.
  - Rising-edge detector on the debounced level produces a 1-cycle pulse: next_p or clr_p.
  - Glitches shorter than DB_CYCLES cycles produce no pulse.
- State encoding: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_CAP=4, S_SHOW=5. Codes 6 and 7 are illegal and go to S_A on the next edge.
- Transitions (clr_p has priority over next_p in every state):
  - S_A: on next_p, alu_a<=sw, then S_B.
  - S_B: on next_p, alu_b<=sw, then S_OP.
  - S_OP: on next_p, alu_ctrl<=op_sw, then S_EXEC.
  - S_EXEC: unconditional, 1 cycle; ALU inputs settle. Then S_CAP.
  - S_CAP: unconditional; res_q<=alu_res, car_q<=alu_car, of_q<=alu_of, done<=1. Then S_SHOW.
  - S_SHOW: hold all outputs. On next_p: done<=0, then S_A. alu_a/alu_b/alu_ctrl/res_q keep their old values until overwritten.
- clr_p in any state, synchronous: alu_a, alu_b, alu_ctrl, res_q, car_q, of_q and done go to 0; state goes to S_A.
- Latency:
  - next_p asserted in the S_OP cycle → done=1 exactly 3 edges later (S_EXEC, S_CAP, S_SHOW).
  - Raw button rise → next_p after 2 + DB_CYCLES + 1 cycles.
- Presses while in S_EXEC or S_CAP are ignored; they are not queued.
- alu_* outputs change only on FSM capture edges, so the ALU never sees switch bounce.
- No arithmetic is performed here; widths pass through unchanged.
- state_o = current state register.

Decomposition:
- Shared package alu_pkg:
  - state enum (S_A..S_SHOW, 3-bit).
  - W/OPW defaults.
  - ALU op-code constants: ADD=0, SUB=1, NOT=2, AND=3, OR=4, XOR=5, LT=6, EQ=7.
- Sub-module btn_debounce (parameter DB_CYCLES; ports clk, rst_n, btn_raw, pulse), instantiated twice.

Test Plan (DB_CYCLES=4, clean button presses held 10 cycles):
- Press sequence with sw=3, sw=5, op_sw=0, then a 4th press → alu_a=3, alu_b=5, alu_ctrl=0; ALU model returns res=8, car=0, of=1; after it, res_q=8, of_q=1, done=1, state_o=5. 4th press → done=0, state_o=0.
- btn_next toggling with 2-cycle pulses for 20 cycles → no next_p, state_o stays 0.
- Load alu_a=7, alu_b=2, then assert btn_clr together with btn_next → all outputs 0, state_o=0, the next press is captured as A.
- Press held continuously for 100 cycles → exactly one next_p; state advances by one only.
- rst_n pulled low for 1 cycle in S_OP after loading A=9, B=1 → outputs 0 immediately (asynchronous, before the next clk), state_o=0.
- Second press arriving during S_EXEC, after next_p in S_OP → ignored; state reaches S_SHOW with done=1 and stays there.
